// File: rtl/qpmm_thread_sched.sv
// qpmm_thread_sched: round-robin issue of per-thread multiply requests onto one fixed-latency QPMM
// pipeline, with a tag pipeline routing results back. Define QPMM_SCHED_CHECK_EN for the mismatch checker.
module qpmm_thread_sched #(
   parameter int N_THREADS = 5,
   parameter int LAT_QPMM  = 76,
   parameter int W         = 289,
   localparam int TIDW     = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_THREADS-1:0]   req_i,
   input  logic [N_THREADS*W-1:0] a_i,
   input  logic [N_THREADS*W-1:0] b_i,
   output logic [N_THREADS-1:0]   gnt_o,
   output logic                   mul_valid_o,
   output logic [W-1:0]           mul_a_o,
   output logic [W-1:0]           mul_b_o,
   output logic [TIDW-1:0]        mul_tid_o,
   input  logic                   res_valid_i,
   input  logic [W-1:0]           res_i,
   output logic [N_THREADS-1:0]   done_o,
   output logic [W-1:0]           res_o,
   output logic [N_THREADS-1:0]   busy_o,
   output logic                   err_o
);

   logic [TIDW-1:0]      ptr;
   logic [N_THREADS-1:0] eligible;
   logic                 grant_any;
   logic [TIDW-1:0]      grant_idx;
   logic [N_THREADS-1:0] grant_oh;
   logic [TIDW-1:0]      ptr_next;
   logic [W-1:0]         sel_a;
   logic [W-1:0]         sel_b;

   logic [LAT_QPMM-1:0]  tag_v;
   logic [TIDW-1:0]      tag_tid [LAT_QPMM];
   logic                 exit_v;
   logic [TIDW-1:0]      exit_tid;
   logic [N_THREADS-1:0] exit_oh;
   logic                 done_fire;
   logic                 stranded;
   logic [N_THREADS-1:0] busy_next;

   // Lowest eligible index at or above ptr wins; otherwise wrap to the lowest eligible index overall.
   always_comb begin
      logic          hi_found;
      logic [TIDW-1:0] hi_idx;
      logic          lo_found;
      logic [TIDW-1:0] lo_idx;
      eligible = req_i & ~busy_o;
      hi_found = 1'b0;
      hi_idx   = '0;
      lo_found = 1'b0;
      lo_idx   = '0;
      for (int t = N_THREADS - 1; t >= 0; t--) begin
         if (eligible[t]) begin
            lo_found = 1'b1;
            lo_idx   = TIDW'(t);
            if (t >= int'(ptr)) begin
               hi_found = 1'b1;
               hi_idx   = TIDW'(t);
            end
         end
      end
      grant_any = lo_found;
      grant_idx = hi_found ? hi_idx : lo_idx;
      ptr_next  = (int'(grant_idx) == N_THREADS - 1) ? '0 : grant_idx + TIDW'(1);
   end

   always_comb begin
      grant_oh = '0;
      sel_a    = '0;
      sel_b    = '0;
      for (int t = 0; t < N_THREADS; t++) begin
         if (grant_idx == TIDW'(t)) begin
            grant_oh[t] = grant_any;
            sel_a       = a_i[t*W +: W];
            sel_b       = b_i[t*W +: W];
         end
      end
   end

   assign exit_v    = tag_v[LAT_QPMM-1];
   assign exit_tid  = tag_tid[LAT_QPMM-1];
   assign done_fire = exit_v & res_valid_i;

   always_comb begin
      exit_oh = '0;
      for (int t = 0; t < N_THREADS; t++) begin
         exit_oh[t] = (exit_tid == TIDW'(t));
      end
   end

   // Grant and completion never target the same thread: a busy thread is never eligible.
   always_comb begin
      busy_next = busy_o;
      if (grant_any) begin
         busy_next = busy_next | grant_oh;
      end
      if (done_fire || stranded) begin
         busy_next = busy_next & ~exit_oh;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr         <= '0;
         gnt_o       <= '0;
         mul_valid_o <= 1'b0;
         mul_a_o     <= '0;
         mul_b_o     <= '0;
         mul_tid_o   <= '0;
         busy_o      <= '0;
         done_o      <= '0;
         res_o       <= '0;
      end else begin
         gnt_o       <= grant_oh;
         mul_valid_o <= grant_any;
         busy_o      <= busy_next;
         done_o      <= done_fire ? exit_oh : '0;
         if (grant_any) begin
            ptr       <= ptr_next;
            mul_a_o   <= sel_a;
            mul_b_o   <= sel_b;
            mul_tid_o <= grant_idx;
         end
         if (done_fire) begin
            res_o <= res_i;
         end
      end
   end

   // Fed from the registered issue strobe so the tag surfaces exactly LAT_QPMM cycles after mul_valid_o.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_v <= '0;
      end else begin
         tag_v[0] <= mul_valid_o;
         for (int s = 1; s < LAT_QPMM; s++) begin
            tag_v[s] <= tag_v[s-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      tag_tid[0] <= mul_tid_o;
      for (int s = 1; s < LAT_QPMM; s++) begin
         tag_tid[s] <= tag_tid[s-1];
      end
   end

`ifdef QPMM_SCHED_CHECK_EN
   assign stranded = exit_v & ~res_valid_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         err_o <= 1'b0;
      end else if (exit_v != res_valid_i) begin
         err_o <= 1'b1;
      end
   end
`else
   assign stranded = 1'b0;
   assign err_o    = 1'b0;
`endif

endmodule
